// File: rtl/com_pkg.sv
// Shared types and defaults for the centroid tracker pixel feeder.
package com_pkg;

  typedef enum logic [1:0] {
    CH_R    = 2'd0,
    CH_G    = 2'd1,
    CH_B    = 2'd2,
    CH_NONE = 2'd3
  } channel_e;

  localparam int DEF_H_ACTIVE     = 1280;
  localparam int DEF_V_ACTIVE     = 720;
  localparam int DEF_GUARD_CYCLES = 40;
  localparam int COUNT_WIDTH      = 21;

  // 5-bit channels are shifted up so every channel compares on the same 6-bit scale.
  function automatic logic [5:0] norm_channel(input channel_e sel, input logic [15:0] px);
    logic [5:0] lvl;
    case (sel)
      CH_R:    lvl = {px[15:11], 1'b0};
      CH_G:    lvl = px[10:5];
      CH_B:    lvl = {px[4:0], 1'b0};
      default: lvl = 6'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pixel_threshold.sv
// Stage 1 registers coordinates, qualifier, thresholds and the normalised channel;
// the stage 2 compare is presented combinationally to the output registers of the top.
module pixel_threshold
  import com_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [15:0] pixel_in,
  input  logic        data_valid_in,
  input  logic [1:0]  channel_sel_in,
  input  logic [5:0]  lower_in,
  input  logic [5:0]  upper_in,
  output logic        s1_valid_out,
  output logic [10:0] s1_x_out,
  output logic [9:0]  s1_y_out,
  output logic        mask_out
);

  logic        valid_q, valid_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [5:0]  level_q, level_d;
  logic [5:0]  lower_q, lower_d;
  logic [5:0]  upper_q, upper_d;
  channel_e    sel_q, sel_d;

  always_comb begin
    valid_d = data_valid_in;
    x_d     = hcount_in;
    y_d     = vcount_in;
    sel_d   = channel_e'(channel_sel_in);
    level_d = norm_channel(sel_d, pixel_in);
    lower_d = lower_in;
    upper_d = upper_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      sel_q   <= CH_NONE;
      level_q <= 6'd0;
      lower_q <= 6'd0;
      upper_q <= 6'd0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      level_q <= level_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
    end
  end

  // An inverted window (lower > upper) can never satisfy both bounds.
  always_comb begin
    mask_out = valid_q && (sel_q != CH_NONE) && (lower_q <= level_q) && (level_q <= upper_q);
  end

  assign s1_valid_out = valid_q;
  assign s1_x_out     = x_q;
  assign s1_y_out     = y_q;

endmodule

// File: rtl/com_pixel_feeder.sv
// Producer side of the centroid tracker: masked coordinate strobes, one tabulate
// pulse per frame with the frame's masked count, and a guard window after it.
module com_pixel_feeder #(
  parameter int H_ACTIVE     = com_pkg::DEF_H_ACTIVE,
  parameter int V_ACTIVE     = com_pkg::DEF_V_ACTIVE,
  parameter int GUARD_CYCLES = com_pkg::DEF_GUARD_CYCLES,
  parameter int COUNT_WIDTH  = com_pkg::COUNT_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic [15:0]            pixel_in,
  input  logic                   data_valid_in,
  input  logic [1:0]             channel_sel_in,
  input  logic [5:0]             lower_in,
  input  logic [5:0]             upper_in,
  output logic [10:0]            x_out,
  output logic [9:0]             y_out,
  output logic                   valid_out,
  output logic                   tabulate_out,
  output logic                   mask_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid_out,
  output logic                   truncated_out
);
  import com_pkg::*;

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  logic        s1_valid_s;
  logic [10:0] s1_x_s;
  logic [9:0]  s1_y_s;
  logic        mask_s;
  logic        end_pix_s, start_pix_s, guard_blk_s;

  logic                   valid_q, valid_d;
  logic                   tab_q, tab_d;
  logic                   mask_q, mask_d;
  logic                   trunc_q, trunc_d;
  logic                   end_seen_q, end_seen_d;
  logic [10:0]            x_q, x_d;
  logic [9:0]             y_q, y_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
  logic [GW-1:0]          guard_q, guard_d;

  pixel_threshold u_threshold (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .pixel_in       (pixel_in),
    .data_valid_in  (data_valid_in),
    .channel_sel_in (channel_sel_in),
    .lower_in       (lower_in),
    .upper_in       (upper_in),
    .s1_valid_out   (s1_valid_s),
    .s1_x_out       (s1_x_s),
    .s1_y_out       (s1_y_s),
    .mask_out       (mask_s)
  );

  // end_seen_q marks the slot right after the frame's last pixel; cnt_q already includes it.
  always_comb begin
    end_pix_s   = s1_valid_s && (s1_x_s == 11'(H_ACTIVE - 1)) && (s1_y_s == 10'(V_ACTIVE - 1));
    start_pix_s = s1_valid_s && (s1_x_s == 11'd0) && (s1_y_s == 10'd0);
    guard_blk_s = (guard_q != {GW{1'b0}});
    valid_d     = 1'b0;
    tab_d       = 1'b0;
    mask_d      = mask_s;
    trunc_d     = trunc_q;
    end_seen_d  = end_pix_s;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    count_out_d = count_out_q;
    if (guard_blk_s) begin
      guard_d = guard_q - GW'(1);
    end else begin
      guard_d = guard_q;
    end

    if (end_seen_q && (cnt_q != {COUNT_WIDTH{1'b0}})) begin
      tab_d       = 1'b1;
      count_out_d = cnt_q;
      cnt_d       = {COUNT_WIDTH{1'b0}};
      guard_d     = GW'(GUARD_CYCLES);
    end else if (!end_seen_q && start_pix_s && (cnt_q != {COUNT_WIDTH{1'b0}})) begin
      tab_d       = 1'b1;
      trunc_d     = 1'b1;
      count_out_d = cnt_q;
      cnt_d       = {COUNT_WIDTH{1'b0}};
      guard_d     = GW'(GUARD_CYCLES);
    end else begin
      if (end_seen_q) begin
        count_out_d = {COUNT_WIDTH{1'b0}};
      end else begin
        count_out_d = count_out_q;
      end
      valid_d = mask_s && !guard_blk_s;
      if (valid_d) begin
        x_d   = s1_x_s;
        y_d   = s1_y_s;
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end else begin
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= 1'b0;
      tab_q       <= 1'b0;
      mask_q      <= 1'b0;
      trunc_q     <= 1'b0;
      end_seen_q  <= 1'b0;
      x_q         <= 11'd0;
      y_q         <= 10'd0;
      cnt_q       <= {COUNT_WIDTH{1'b0}};
      count_out_q <= {COUNT_WIDTH{1'b0}};
      guard_q     <= {GW{1'b0}};
    end else begin
      valid_q     <= valid_d;
      tab_q       <= tab_d;
      mask_q      <= mask_d;
      trunc_q     <= trunc_d;
      end_seen_q  <= end_seen_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      count_out_q <= count_out_d;
      guard_q     <= guard_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign valid_out       = valid_q;
  assign tabulate_out    = tab_q;
  assign count_valid_out = tab_q;
  assign mask_out        = mask_q;
  assign count_out       = count_out_q;
  assign truncated_out   = trunc_q;

endmodule
